// File: rtl/source_dat_gen_pkg.sv
// Shared types and default constants for the two-channel test-data source.
package source_dat_pkg;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_INC   = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_ROT   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int          DEF_WIDTH       = 12;
  localparam int          DEF_BURST_LEN   = 16;
  localparam logic [11:0] DEF_MASTER_SEED = 12'h702;
  localparam logic [11:0] DEF_SLAVE_SEED  = 12'hE6C;
  localparam logic [11:0] DEF_LFSR_TAPS   = 12'h829;

endpackage

// File: rtl/source_dat_gen_if.sv
// Valid/ready bundle for the master and slave data channels.
interface source_dat_if #(
  parameter int WIDTH = 12
);
  logic             MASTER_valid;
  logic             MASTER_ready;
  logic [WIDTH-1:0] MASTER_dat;
  logic             SLAVE_valid;
  logic             SLAVE_ready;
  logic [WIDTH-1:0] SLAVE_dat;

  modport master (
    output MASTER_valid, MASTER_dat, SLAVE_valid, SLAVE_dat,
    input  MASTER_ready, SLAVE_ready
  );

  modport slave (
    input  MASTER_valid, MASTER_dat, SLAVE_valid, SLAVE_dat,
    output MASTER_ready, SLAVE_ready
  );
endinterface

// File: rtl/source_dat_gen_pattern_chan.sv
// One handshaked pattern channel: data register, word counter and valid flag.
module pattern_chan
  import source_dat_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               BURST_LEN = DEF_BURST_LEN,
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(DEF_MASTER_SEED),
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEF_LFSR_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  mode_e            mode,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dat,
  output logic             last
);
  localparam int CW = $clog2(BURST_LEN + 1);

  logic [CW-1:0]    cnt;
  logic             xfer;
  logic             at_end;
  logic [WIDTH-1:0] seed_load;

  function automatic logic [WIDTH-1:0] next_word(mode_e m, logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    case (m)
      MODE_INC:  r = d + WIDTH'(1);
      MODE_LFSR: r = {d[WIDTH-2:0], 1'b0} ^ (d[WIDTH-1] ? LFSR_TAPS : '0);
      MODE_ROT:  r = {d[WIDTH-2:0], d[WIDTH-1]};
      default:   r = d;
    endcase
    return r;
  endfunction

  assign xfer      = valid & ready;
  assign at_end    = (cnt == CW'(BURST_LEN - 1));
  // an all-zero LFSR state would never leave zero
  assign seed_load = (mode == MODE_LFSR && SEED == '0) ? WIDTH'(1) : SEED;
  // finished, or finishing on this edge, so the FSM can leave RUN without a bubble
  assign last      = (cnt == CW'(BURST_LEN)) | (xfer & at_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dat   <= SEED;
      cnt   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dat   <= seed_load;
      cnt   <= '0;
    end else if (xfer) begin
      cnt <= cnt + CW'(1);
      dat <= next_word(mode, dat);
      if (at_end) valid <= 1'b0;
    end
  end
endmodule

// File: rtl/source_dat_gen.sv
// Burst controller driving two independent pattern channels (master, slave).
module source_dat_gen
  import source_dat_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter int               BURST_LEN   = DEF_BURST_LEN,
  parameter logic [WIDTH-1:0] MASTER_SEED = WIDTH'(DEF_MASTER_SEED),
  parameter logic [WIDTH-1:0] SLAVE_SEED  = WIDTH'(DEF_SLAVE_SEED),
  parameter logic [WIDTH-1:0] LFSR_TAPS   = WIDTH'(DEF_LFSR_TAPS)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  source_dat_if.master bus,
  output logic         busy,
  output logic         done
);
  state_e state, state_nxt;
  mode_e  mode_q, chan_mode;
  logic   load;
  logic   m_last, s_last;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN:  if (m_last && s_last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // the load cycle uses the incoming mode so the seed fix-up sees it
  assign chan_mode = load ? mode_e'(mode) : mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mode_q <= MODE_CONST;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_RUN);
      done  <= (state_nxt == ST_DONE);
      if (load) mode_q <= mode_e'(mode);
    end
  end

  pattern_chan #(
    .WIDTH(WIDTH), .BURST_LEN(BURST_LEN), .SEED(MASTER_SEED), .LFSR_TAPS(LFSR_TAPS)
  ) u_master (
    .clk(clk), .rst_n(rst_n), .load(load), .mode(chan_mode),
    .ready(bus.MASTER_ready), .valid(bus.MASTER_valid), .dat(bus.MASTER_dat), .last(m_last)
  );

  pattern_chan #(
    .WIDTH(WIDTH), .BURST_LEN(BURST_LEN), .SEED(SLAVE_SEED), .LFSR_TAPS(LFSR_TAPS)
  ) u_slave (
    .clk(clk), .rst_n(rst_n), .load(load), .mode(chan_mode),
    .ready(bus.SLAVE_ready), .valid(bus.SLAVE_valid), .dat(bus.SLAVE_dat), .last(s_last)
  );
endmodule

// File: tb/tb_source_dat_gen.sv
// Bench for source_dat_gen: two instances (default seeds, and zero/FFE seeds) driven in lockstep.
module tb_source_dat_gen;
  localparam int          W    = 12;
  localparam int          BL   = 16;
  localparam logic [11:0] TAPS = 12'h829;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       busy1, done1, busy2, done2;
  logic       rm = 1'b1, rs = 1'b1;

  source_dat_if #(.WIDTH(W)) bus1 ();
  source_dat_if #(.WIDTH(W)) bus2 ();

  source_dat_gen #(.WIDTH(W), .BURST_LEN(BL), .MASTER_SEED(12'h702), .SLAVE_SEED(12'hE6C),
                   .LFSR_TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .bus(bus1.master),
    .busy(busy1), .done(done1));

  source_dat_gen #(.WIDTH(W), .BURST_LEN(BL), .MASTER_SEED(12'h000), .SLAVE_SEED(12'hFFE),
                   .LFSR_TAPS(TAPS)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .bus(bus2.master),
    .busy(busy2), .done(done2));

  assign bus1.MASTER_ready = rm;
  assign bus2.MASTER_ready = rm;
  assign bus1.SLAVE_ready  = rs;
  assign bus2.SLAVE_ready  = rs;

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [11:0] seeds[4] = '{12'h702, 12'hE6C, 12'h000, 12'hFFE};
  logic [11:0] got[4][BL];
  int ncnt[4], lastc[4];
  int done_c, done_n, busy_err, stab_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] model_next(input int m, input logic [11:0] d);
    int v = int'(d);
    case (m)
      1:       v = (v + 1) % 4096;
      2:       v = ((v * 2) % 4096) ^ ((v >= 2048) ? int'(TAPS) : 0);
      3:       v = ((v * 2) % 4096) + (v / 2048);
      default: v = v;
    endcase
    return v[11:0];
  endfunction

  function automatic logic [11:0] model_word(input int m, input int ch, input int k);
    logic [11:0] d = seeds[ch];
    if (m == 2 && d == 12'h000) d = 12'h001;
    for (int j = 0; j < k; j++) d = model_next(m, d);
    return d;
  endfunction

  task automatic run_burst(input int m, input int stall, input bit rnd, input bit guard,
                           input int rst_at, input string tag);
    logic [3:0]  v, r, pv, pr;
    logic [11:0] d[4], pd[4];
    int c;
    bit fin;
    for (int i = 0; i < 4; i++) begin ncnt[i] = 0; lastc[i] = 0; end
    done_c = 0; done_n = 0; busy_err = 0; stab_err = 0;
    pv = '0; pr = '0; c = 0; fin = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 2'(m); rm = 1'b1; rs = 1'b1;
    while (!fin) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (guard && c == 3) begin start = 1'b1; mode = ~2'(m); end
      rm = rnd ? ($urandom_range(0, 3) != 0) : (c > stall);
      rs = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #0;
      v = {bus2.SLAVE_valid, bus2.MASTER_valid, bus1.SLAVE_valid, bus1.MASTER_valid};
      d = '{bus1.MASTER_dat, bus1.SLAVE_dat, bus2.MASTER_dat, bus2.SLAVE_dat};
      r = {rs, rm, rs, rm};
      if (stall > 0 && c == stall) chk({tag, " stall hold"}, {v[0], d[0]}, {1'b1, 12'h702});
      for (int i = 0; i < 4; i++) begin
        if (pv[i] && !pr[i] && (!v[i] || d[i] !== pd[i])) stab_err++;
        if (v[i] && r[i]) begin
          if (ncnt[i] < BL) got[i][ncnt[i]] = d[i];
          ncnt[i]++;
          lastc[i] = c;
        end
      end
      if (done1 !== done2 || busy1 !== busy2) busy_err++;
      if (done1) begin
        done_n++;
        if (done_c == 0) done_c = c;
      end
      if (done_c == 0 && busy1 !== 1'b1) busy_err++;
      if (done_c != 0 && c > done_c) begin
        chk({tag, " busy after done"}, busy1, 1'b0);
        fin = 1'b1;
      end
      if (rst_at > 0 && ncnt[0] == rst_at) fin = 1'b1;
      if (c > 300) begin
        total++; bad++;
        $display("FAIL %s timeout: got no done after %0d cycles, required done", tag, c);
        fin = 1'b1;
      end
      pv = v; pr = r; pd = d;
    end
  endtask

  task automatic check_burst(input int m, input int exp_done, input string tag);
    int mx = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s ch%0d count", tag, i), ncnt[i], BL);
      for (int k = 0; k < BL; k++)
        chk($sformatf("%s ch%0d word%0d", tag, i, k), got[i][k], model_word(m, i, k));
      if (lastc[i] > mx) mx = lastc[i];
    end
    chk({tag, " done cycle"}, done_c, mx + 1);
    if (exp_done > 0) chk({tag, " done abs cycle"}, done_c, exp_done);
    chk({tag, " done pulses"}, done_n, 1);
    chk({tag, " busy/lockstep errs"}, busy_err, 0);
    chk({tag, " data stability errs"}, stab_err, 0);
  endtask

  typedef struct {
    int          m;
    logic [11:0] mw[4];
    logic [11:0] sw[4];
  } vec_t;
  vec_t tbl[4];

  initial begin
    tbl[0] = '{0, '{12'h702, 12'h702, 12'h702, 12'h702}, '{12'hFFE, 12'hFFE, 12'hFFE, 12'hFFE}};
    tbl[1] = '{1, '{12'h702, 12'h703, 12'h704, 12'h705}, '{12'hFFE, 12'hFFF, 12'h000, 12'h001}};
    tbl[2] = '{2, '{12'h702, 12'hE04, 12'h421, 12'h842}, '{12'hFFE, 12'h7D5, 12'hFAA, 12'h77D}};
    tbl[3] = '{3, '{12'h702, 12'hE04, 12'hC09, 12'h813}, '{12'hFFE, 12'hFFD, 12'hFFB, 12'hFF7}};

    #12;
    chk("reset valids", {bus2.SLAVE_valid, bus2.MASTER_valid, bus1.SLAVE_valid, bus1.MASTER_valid}, 0);
    chk("reset m dat", bus1.MASTER_dat, 12'h702);
    chk("reset s dat", bus1.SLAVE_dat, 12'hE6C);
    chk("reset m2 dat", bus2.MASTER_dat, 12'h000);
    chk("reset busy/done", {busy1, done1, busy2, done2}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_burst(tbl[i].m, 0, 1'b0, 1'b0, 0, $sformatf("tbl%0d", i));
      check_burst(tbl[i].m, 17, $sformatf("tbl%0d", i));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("tbl%0d m word%0d", i, k), got[0][k], tbl[i].mw[k]);
        chk($sformatf("tbl%0d s2 word%0d", i, k), got[3][k], tbl[i].sw[k]);
      end
    end
    chk("lfsr zero seed fixup", model_word(2, 2, 0), 12'h001);

    run_burst(1, 5, 1'b0, 1'b0, 0, "stall");
    check_burst(1, 22, "stall");
    chk("stall slave first", lastc[1] < lastc[0], 1'b1);

    run_burst(2, 0, 1'b0, 1'b1, 0, "guard");
    check_burst(2, 17, "guard");

    repeat (6) begin
      int m = int'($urandom_range(0, 3));
      run_burst(m, 0, 1'b1, 1'b0, 0, "rand");
      check_burst(m, 0, "rand");
    end

    run_burst(1, 0, 1'b0, 1'b0, 7, "rst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst valids", {bus2.SLAVE_valid, bus2.MASTER_valid, bus1.SLAVE_valid, bus1.MASTER_valid}, 0);
    chk("rst m dat", bus1.MASTER_dat, 12'h702);
    chk("rst s dat", bus1.SLAVE_dat, 12'hE6C);
    chk("rst s2 dat", bus2.SLAVE_dat, 12'hFFE);
    chk("rst busy", busy1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst no done %0d", k), done1, 1'b0);
    end
    chk("rst no done before", done_n, 0);
    rst_n = 1'b1;
    run_burst(3, 0, 1'b0, 1'b0, 0, "after rst");
    check_burst(3, 17, "after rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/source_dat_gen.md
# source_dat_gen

Parametrised, handshaked test-data source for the master/slave exchange labs. It drives two independent channels, master and slave, each producing a burst of `BURST_LEN` words on a valid/ready interface. Each burst starts from a per-channel seed. Four pattern modes are available: constant, increment, LFSR and walking rotate. It sits upstream of the master and slave transfer blocks and replaces fixed tie-off data sources with a sequenced generator.

## Interface
Parameters:
- `WIDTH`, 12: data word width (≥ 2).
- `BURST_LEN`, 16: words per channel per burst (≥ 1).
- `MASTER_SEED`, 12'h702: master channel first word.
- `SLAVE_SEED`, 12'hE6C: slave channel first word.
- `LFSR_TAPS`, 12'h829: Galois feedback mask.

Ports:
- `clk`  in  1: the block's only clock; everything is sampled on its rising edge.
- `rst_n`  in  1: asynchronous reset, active low.
- `start`  in  1: begin a burst; honoured only in IDLE.
- `mode`  in  2: pattern select, latched at `start`. 0 = constant, 1 = increment, 2 = LFSR, 3 = rotate-left.
- `MASTER_valid`  out  1: master word available.
- `MASTER_ready`  in  1: master consumer accepts.
- `MASTER_dat`  out  WIDTH: master data word.
- `SLAVE_valid`  out  1: slave word available.
- `SLAVE_ready`  in  1: slave consumer accepts.
- `SLAVE_dat`  out  WIDTH: slave data word.
- `busy`  out  1: burst in progress.
- `done`  out  1: one-cycle pulse when both channels have finished.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start`. On that transition, load both data registers with their seeds, clear both word counters, latch `mode`.
  - RUN→DONE when both channels have completed `BURST_LEN` transfers.
  - DONE→IDLE unconditionally after one cycle.
- `start` in RUN or DONE is ignored. `mode` changes during RUN are ignored.
- Each channel is independent:
  - A transfer occurs when valid && ready.
  - On a transfer, the counter increments and the data register advances to the next pattern value.
  - After the `BURST_LEN`-th transfer, that channel's valid deasserts and stays low until the next burst.
- Next-value rules. All arithmetic is modulo 2^WIDTH.
  - Constant: the data register is unchanged.
  - Increment: d+1. All-ones wraps to 0.
  - LFSR: `{d[W-2:0],0} ^ (d[W-1] ? LFSR_TAPS : 0)`. A zero seed is replaced by 1 at load so the LFSR never locks.
  - Rotate: `{d[W-2:0], d[W-1]}`.
- Valid/data rules:
  - Data is stable while valid is high and ready is low.
  - Valid never drops without a transfer, except on reset.
- `busy` = (state == RUN). `done` = (state == DONE).
- Both channels finishing in the same cycle produce a single `done` pulse.

## Timing
- Reset values:
  - state IDLE; `busy`=0; `done`=0; both valids 0.
  - `MASTER_dat`=MASTER_SEED; `SLAVE_dat`=SLAVE_SEED.
  - Counters 0; latched mode 0.
- `start` sampled at edge N → `busy` and both valids high after edge N. The first word is presented in cycle N+1.
- With ready held high, one word per cycle per channel. The last transfer on the slower channel occurs at edge M → `done`=1 in cycle M+1, `busy`=0 from cycle M+1.
- The earliest next `start` is accepted at edge M+2, i.e. when the state is IDLE.
- `rst_n` low mid-burst immediately forces all reset values. There are no partial transfers and no `done` pulse.
- All outputs are registered; there are no combinational paths from ready to valid.

## Structure
- Shared package `source_dat_pkg`:
  - mode enum (`MODE_CONST`, `MODE_INC`, `MODE_LFSR`, `MODE_ROT`);
  - state enum;
  - default seed and tap constants.
- One sub-module, `pattern_chan`, instantiated twice with the seed as a parameter. It holds the data register, word counter, valid flag and next-value function, and exposes a `last` flag to the top FSM.

## Test plan
- Mode 0, both readies high, `start` pulse:
  - 16 words of 0x702 on master and 16 words of 0xE6C on slave, in cycles N+1..N+16;
  - `done` in cycle N+17.
- Mode 1:
  - master 0x702, 0x703 … 0x711;
  - with `SLAVE_SEED`=12'hFFE, slave 0xFFE, 0xFFF, 0x000, 0x001 …
- Mode 2, master: 0x702, 0xE04, 0x421, 0x842 … Mode 3, master: 0x702, 0xE04, 0xC09, 0x813 …
- Backpressure:
  - `MASTER_ready` low for 5 cycles after the first word → `MASTER_dat` held at 0x702 with valid high;
  - slave completes first; `done` only after the master's 16th transfer.
- Guarding:
  - `start` asserted during RUN and `mode` toggled during RUN → no restart, pattern unchanged.
  - `rst_n` pulsed low after the 7th transfer → valids 0, data back to seeds, no `done`;
  - a new `start` runs a full 16-word burst.
